// File: rtl/cameralink_pkg.sv
// Shared encodings and defaults for the Camera Link line reader.
package cameralink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } cl_state_e;

  localparam int DEF_N_CH       = 2;
  localparam int DEF_CH_W       = 24;
  localparam int DEF_PIX_PER_CH = 2;
  localparam int DEF_LW_W       = 16;
  localparam int DEF_STALL_MAX  = 1023;

  // Pixels carried by one lock-step beat across all channels.
  function automatic int calc_ppb(input int n_ch, input int pix_per_ch);
    return n_ch * pix_per_ch;
  endfunction

endpackage

// File: rtl/cl_skid_buf.sv
// Two-entry valid/ready buffer; head entry drives the outputs directly from flops.
module cl_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ
);

  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic         hv_q, hv_d, tv_q, tv_d;
  logic         pop_s;

  // Next-state of the two entries; the upstream never pushes into a full buffer.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    hv_d   = hv_q;
    tv_d   = tv_q;
    pop_s  = hv_q & out_ready;
    if (flush) begin
      hv_d = 1'b0;
      tv_d = 1'b0;
    end else if (pop_s) begin
      if (tv_q) begin
        head_d = tail_q;
        tv_d   = in_valid;
        if (in_valid) begin
          tail_d = in_data;
        end else begin
          tail_d = tail_q;
        end
      end else begin
        hv_d = in_valid;
        if (in_valid) begin
          head_d = in_data;
        end else begin
          head_d = head_q;
        end
      end
    end else if (in_valid) begin
      if (hv_q) begin
        tail_d = in_data;
        tv_d   = 1'b1;
      end else begin
        head_d = in_data;
        hv_d   = 1'b1;
      end
    end else begin
      hv_d = hv_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= {W{1'b0}};
      tail_q <= {W{1'b0}};
      hv_q   <= 1'b0;
      tv_q   <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      hv_q   <= hv_d;
      tv_q   <= tv_d;
    end
  end

  assign out_valid = hv_q;
  assign out_data  = head_q;
  assign occ       = {1'b0, hv_q} + {1'b0, tv_q};

endmodule

// File: rtl/cameralink_line_reader.sv
// Lock-step reader for N channel FIFOs: one beat per line slot, SOL/EOL tagging,
// per-frame line counting and stall detection on mis-aligned channels.
module cameralink_line_reader
  import cameralink_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int CH_W       = DEF_CH_W,
  parameter int PIX_PER_CH = DEF_PIX_PER_CH,
  parameter int LW_W       = DEF_LW_W,
  parameter int STALL_MAX  = DEF_STALL_MAX
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 frame_valid,
  input  logic                 new_frame,
  input  logic [N_CH-1:0]      ch_line_rdy,
  input  logic [N_CH-1:0]      ch_empty,
  input  logic [N_CH*CH_W-1:0] ch_dout,
  output logic                 ch_rd_en,
  input  logic [LW_W-1:0]      lineWidth,
  output logic [N_CH*CH_W-1:0] pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_sol,
  output logic                 pix_eol,
  output logic [LW_W-1:0]      line_cnt,
  output logic                 err_stall,
  input  logic                 err_clr
);

  localparam int             DW         = N_CH * CH_W;
  localparam int             SW         = $clog2(STALL_MAX + 1);
  localparam logic [LW_W:0]  PPB_X      = (LW_W + 1)'(calc_ppb(N_CH, PIX_PER_CH));
  localparam logic [SW-1:0]  STALL_LAST = SW'(STALL_MAX - 1);

  cl_state_e     state_q, state_d;
  logic [LW_W:0] lw_q, lw_d, rd_cnt_q, rd_cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [LW_W-1:0] line_cnt_q, line_cnt_d;
  logic          sol_pend_q, sol_pend_d, inflight_q, inflight_d;
  logic          sol_inf_q, sol_inf_d, eol_inf_q, eol_inf_d, err_q, err_d;
  logic          rd_en_s, flush_s, partial_s, room_s, last_s, eol_out_s;
  logic [1:0]    occ_s;
  logic [DW+1:0] skid_out_s;

  // Sequencing of one line; ch_rd_en must see this cycle's ch_empty, so it stays combinational.
  always_comb begin
    state_d    = state_q;
    lw_d       = lw_q;
    rd_cnt_d   = rd_cnt_q;
    stall_d    = stall_q;
    line_cnt_d = line_cnt_q;
    sol_pend_d = sol_pend_q;
    inflight_d = 1'b0;
    sol_inf_d  = sol_inf_q;
    eol_inf_d  = eol_inf_q;
    err_d      = err_clr ? 1'b0 : err_q;
    rd_en_s    = 1'b0;
    flush_s    = 1'b0;
    partial_s  = (|ch_empty) & ~(&ch_empty);
    room_s     = ({1'b0, occ_s} + {2'b00, inflight_q}) < 3'd2;
    last_s     = (rd_cnt_q + PPB_X) >= lw_q;
    eol_out_s  = pix_valid & pix_ready & pix_eol;
    if (new_frame) begin
      flush_s    = 1'b1;
      line_cnt_d = {LW_W{1'b0}};
      stall_d    = {SW{1'b0}};
      state_d    = frame_valid ? ST_WAIT : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_valid) state_d = ST_WAIT;
          else             state_d = ST_IDLE;
        end
        ST_WAIT: begin
          if (!frame_valid) begin
            state_d = ST_IDLE;
          end else if (&ch_line_rdy) begin
            state_d    = ST_READ;
            lw_d       = (lineWidth == {LW_W{1'b0}}) ? PPB_X : {1'b0, lineWidth};
            rd_cnt_d   = {(LW_W + 1){1'b0}};
            sol_pend_d = 1'b1;
            stall_d    = {SW{1'b0}};
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_READ: begin
          rd_en_s = ~(|ch_empty) & room_s;
          if (rd_en_s) begin
            inflight_d = 1'b1;
            sol_inf_d  = sol_pend_q;
            eol_inf_d  = last_s;
            sol_pend_d = 1'b0;
            rd_cnt_d   = rd_cnt_q + PPB_X;
            stall_d    = {SW{1'b0}};
            state_d    = last_s ? ST_DONE : ST_READ;
          end else if (partial_s) begin
            if (stall_q == STALL_LAST) begin
              err_d   = 1'b1;
              stall_d = {SW{1'b0}};
              state_d = ST_WAIT;
            end else begin
              stall_d = stall_q + SW'(1);
            end
          end else begin
            stall_d = stall_q;
          end
        end
        ST_DONE: begin
          if (eol_out_s) begin
            line_cnt_d = (&line_cnt_q) ? line_cnt_q : line_cnt_q + LW_W'(1);
            state_d    = frame_valid ? ST_WAIT : ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      lw_q       <= {(LW_W + 1){1'b0}};
      rd_cnt_q   <= {(LW_W + 1){1'b0}};
      stall_q    <= {SW{1'b0}};
      line_cnt_q <= {LW_W{1'b0}};
      sol_pend_q <= 1'b0;
      inflight_q <= 1'b0;
      sol_inf_q  <= 1'b0;
      eol_inf_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lw_q       <= lw_d;
      rd_cnt_q   <= rd_cnt_d;
      stall_q    <= stall_d;
      line_cnt_q <= line_cnt_d;
      sol_pend_q <= sol_pend_d;
      inflight_q <= inflight_d;
      sol_inf_q  <= sol_inf_d;
      eol_inf_q  <= eol_inf_d;
      err_q      <= err_d;
    end
  end

  cl_skid_buf #(.W(DW + 2)) u_skid (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .flush    (flush_s),
    .in_valid (inflight_q & ~flush_s),
    .in_data  ({ch_dout, sol_inf_q, eol_inf_q}),
    .out_valid(pix_valid),
    .out_data (skid_out_s),
    .out_ready(pix_ready),
    .occ      (occ_s)
  );

  assign ch_rd_en  = rd_en_s;
  assign pix_data  = skid_out_s[DW+1:2];
  assign pix_sol   = skid_out_s[1];
  assign pix_eol   = skid_out_s[0];
  assign line_cnt  = line_cnt_q;
  assign err_stall = err_q;

endmodule
